// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter that shares one SRAM between several single-word requesters.
// Runs one read or write at a time through the SRAM's strobe/ready handshake and returns the result.
module sram_port_arbiter #(
    parameter int n_req          = 4,
    parameter int data_width     = 16,
    parameter int addr_width     = 13,
    parameter int timeout_cycles = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [n_req-1:0]             req_valid,
    input  logic [n_req-1:0]             req_write,
    input  logic [n_req*addr_width-1:0]  req_addr,
    input  logic [n_req*data_width-1:0]  req_wdata,
    output logic [n_req-1:0]             req_ready,
    output logic [n_req-1:0]             resp_valid,
    output logic [data_width-1:0]        resp_data,
    output logic                         resp_error,
    output logic                         timeout,
    output logic                         busy,
    output logic                         mem_read,
    output logic                         mem_write,
    output logic [addr_width-1:0]        mem_read_addr,
    output logic [addr_width-1:0]        mem_write_addr,
    output logic [data_width-1:0]        mem_data_in,
    input  logic [data_width-1:0]        mem_data_out,
    input  logic                         mem_read_ready,
    input  logic                         mem_write_ready,
    input  logic                         mem_invalid_read,
    input  logic                         mem_invalid_write
);

    localparam int IDX_W = (n_req > 1) ? $clog2(n_req) : 1;
    localparam int CNT_W = $clog2(timeout_cycles + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout_cycles - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        win_q, win_d;
    logic                    op_write_q, op_write_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    mem_read_q, mem_read_d;
    logic                    mem_write_q, mem_write_d;
    logic [addr_width-1:0]   mem_read_addr_q, mem_read_addr_d;
    logic [addr_width-1:0]   mem_write_addr_q, mem_write_addr_d;
    logic [data_width-1:0]   mem_data_in_q, mem_data_in_d;
    logic [n_req-1:0]        resp_valid_q, resp_valid_d;
    logic [data_width-1:0]   resp_data_q, resp_data_d;
    logic                    resp_error_q, resp_error_d;
    logic                    timeout_q, timeout_d;
    logic                    busy_q, busy_d;

    logic [IDX_W-1:0]        cand_s;
    logic [IDX_W-1:0]        scan_idx_s;
    int                      scan_sum_s;
    logic                    grant_s;
    logic                    op_ready_s;
    logic                    op_invalid_s;

    // Round-robin candidate: highest-priority pending requester after rr_ptr.
    always_comb begin
        cand_s     = '0;
        scan_idx_s = '0;
        scan_sum_s = 0;
        for (int i = n_req; i >= 1; i--) begin
            scan_sum_s = int'(rr_ptr_q) + i;
            scan_idx_s = IDX_W'((scan_sum_s >= n_req) ? (scan_sum_s - n_req) : scan_sum_s);
            cand_s     = req_valid[scan_idx_s] ? scan_idx_s : cand_s;
        end
        // Grant needs the SRAM side for the candidate's own op to be ready; reset masks the comb strobe.
        grant_s      = (|req_valid) && reset &&
                       (req_write[cand_s] ? mem_write_ready : mem_read_ready);
        op_ready_s   = op_write_q ? mem_write_ready : mem_read_ready;
        op_invalid_s = op_write_q ? mem_invalid_write : mem_invalid_read;
    end

    // Next-state and registered-output logic for the IDLE/ISSUE/WAIT/RESP sequencer.
    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        win_d            = win_q;
        op_write_d       = op_write_q;
        err_d            = err_q;
        cnt_d            = cnt_q;
        mem_read_d       = 1'b0;
        mem_write_d      = 1'b0;
        mem_read_addr_d  = mem_read_addr_q;
        mem_write_addr_d = mem_write_addr_q;
        mem_data_in_d    = mem_data_in_q;
        resp_valid_d     = '0;
        resp_data_d      = '0;
        resp_error_d     = 1'b0;
        timeout_d        = 1'b0;
        req_ready        = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    req_ready[cand_s] = 1'b1;
                    win_d      = cand_s;
                    rr_ptr_d   = cand_s;
                    op_write_d = req_write[cand_s];
                    err_d      = 1'b0;
                    state_d    = ST_ISSUE;
                    if (req_write[cand_s]) begin
                        mem_write_d      = 1'b1;
                        mem_write_addr_d = req_addr[int'(cand_s)*addr_width +: addr_width];
                        mem_data_in_d    = req_wdata[int'(cand_s)*data_width +: data_width];
                    end else begin
                        mem_read_d      = 1'b1;
                        mem_read_addr_d = req_addr[int'(cand_s)*addr_width +: addr_width];
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                err_d = err_q | op_invalid_s;
                // Ready is only trusted once it has had a cycle to drop after the strobe.
                if (op_ready_s && (cnt_q != '0)) begin
                    state_d              = ST_RESP;
                    resp_valid_d[win_q]  = 1'b1;
                    resp_data_d          = op_write_q ? '0 : mem_data_out;
                    resp_error_d         = err_q | op_invalid_s;
                end else if (cnt_q == CNT_LAST) begin
                    state_d              = ST_RESP;
                    err_d                = 1'b1;
                    timeout_d            = 1'b1;
                    resp_valid_d[win_q]  = 1'b1;
                    resp_error_d         = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; rr_ptr resets to the last index so requester 0 wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            rr_ptr_q         <= IDX_W'(n_req - 1);
            win_q            <= '0;
            op_write_q       <= 1'b0;
            err_q            <= 1'b0;
            cnt_q            <= '0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_read_addr_q  <= '0;
            mem_write_addr_q <= '0;
            mem_data_in_q    <= '0;
            resp_valid_q     <= '0;
            resp_data_q      <= '0;
            resp_error_q     <= 1'b0;
            timeout_q        <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            rr_ptr_q         <= rr_ptr_d;
            win_q            <= win_d;
            op_write_q       <= op_write_d;
            err_q            <= err_d;
            cnt_q            <= cnt_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_read_addr_q  <= mem_read_addr_d;
            mem_write_addr_q <= mem_write_addr_d;
            mem_data_in_q    <= mem_data_in_d;
            resp_valid_q     <= resp_valid_d;
            resp_data_q      <= resp_data_d;
            resp_error_q     <= resp_error_d;
            timeout_q        <= timeout_d;
            busy_q           <= busy_d;
        end
    end

    assign resp_valid     = resp_valid_q;
    assign resp_data      = resp_data_q;
    assign resp_error     = resp_error_q;
    assign timeout        = timeout_q;
    assign busy           = busy_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_read_addr  = mem_read_addr_q;
    assign mem_write_addr = mem_write_addr_q;
    assign mem_data_in    = mem_data_in_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: SRAM stub with optional read stall, round-robin and memory
// reference model, directed scenarios followed by randomized request batches.
module tb_sram_port_arbiter;

    localparam int N     = 4;
    localparam int AW    = 13;
    localparam int DW    = 16;
    localparam int TO    = 16;
    localparam int DEPTH = 6144;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [N-1:0]      req_valid, req_write, req_ready, resp_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [DW-1:0]     resp_data;
    logic              resp_error, timeout, busy, mem_read, mem_write;
    logic [AW-1:0]     mem_read_addr, mem_write_addr;
    logic [DW-1:0]     mem_data_in;
    logic [DW-1:0]     mem_data_out      = '0;
    logic              mem_read_ready    = 1'b1;
    logic              mem_write_ready   = 1'b1;
    logic              mem_invalid_read  = 1'b0;
    logic              mem_invalid_write = 1'b0;

    sram_port_arbiter #(
        .n_req(N), .data_width(DW), .addr_width(AW), .timeout_cycles(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_error(resp_error), .timeout(timeout), .busy(busy),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_read_ready(mem_read_ready), .mem_write_ready(mem_write_ready),
        .mem_invalid_read(mem_invalid_read), .mem_invalid_write(mem_invalid_write)
    );

    // SRAM stub: ready drops the cycle after a strobe and returns one cycle later
    logic          stall_read = 1'b0;
    logic          rd_pend    = 1'b0;
    logic          wr_pend    = 1'b0;
    logic [AW-1:0] rd_addr    = '0;
    logic [DW-1:0] sram [0:8191] = '{default: 16'h0000};

    always @(posedge clk) begin
        mem_invalid_read  <= 1'b0;
        mem_invalid_write <= 1'b0;
        if (mem_read) begin
            mem_read_ready   <= 1'b0;
            rd_pend          <= 1'b1;
            rd_addr          <= mem_read_addr;
            mem_invalid_read <= (int'(mem_read_addr) >= DEPTH);
        end else if (rd_pend && !stall_read) begin
            mem_read_ready <= 1'b1;
            rd_pend        <= 1'b0;
            mem_data_out   <= (int'(rd_addr) < DEPTH) ? sram[rd_addr] : 16'h0000;
        end
        if (mem_write) begin
            mem_write_ready   <= 1'b0;
            wr_pend           <= 1'b1;
            mem_invalid_write <= (int'(mem_write_addr) >= DEPTH);
            if (int'(mem_write_addr) < DEPTH) sram[mem_write_addr] <= mem_data_in;
        end else if (wr_pend) begin
            mem_write_ready <= 1'b1;
            wr_pend         <= 1'b0;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: one-hot invariants and strobe exactly one cycle after each grant with grant's fields
    int            g_cyc = -100;
    logic          g_w   = 1'b0;
    logic [AW-1:0] g_a   = '0;
    logic [DW-1:0] g_d   = '0;
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            chk("resp_onehot0", 32'($onehot0(resp_valid)), 32'd1);
            chk("strobes_exclusive", 32'(mem_read & mem_write), 32'd0);
            if (req_ready != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (req_ready[i]) begin
                        g_w <= req_write[i];
                        g_a <= req_addr[i*AW +: AW];
                        g_d <= req_wdata[i*DW +: DW];
                    end
                end
                g_cyc <= cyc;
            end else if (cyc == g_cyc + 1 || mem_read || mem_write) begin
                chk("strobe_cycle", cyc, g_cyc + 1);
                chk("strobe_read", 32'(mem_read), 32'(!g_w));
                chk("strobe_write", 32'(mem_write), 32'(g_w));
                if (g_w) begin
                    chk("strobe_waddr", 32'(mem_write_addr), 32'(g_a));
                    chk("strobe_wdata", 32'(mem_data_in), 32'(g_d));
                end else begin
                    chk("strobe_raddr", 32'(mem_read_addr), 32'(g_a));
                end
            end
        end
    end

    // Reference model: flat memory, round-robin pointer, expected completions
    typedef struct {
        int            cyc;
        int            idx;
        logic [DW-1:0] data;
        logic          err;
        logic          tmo;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model_mem [0:8191] = '{default: 16'h0000};
    int            model_last;
    logic          drv_write [N];
    logic [AW-1:0] drv_addr  [N];
    logic [DW-1:0] drv_wdata [N];
    logic [DW-1:0] last_data;
    logic          last_err;
    logic          last_tmo;

    function automatic int rr_next(input logic [N-1:0] m, input int last);
        int j;
        for (int i = 1; i <= N; i++) begin
            j = (last + i) % N;
            if (m[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return AW'($urandom_range(DEPTH, 8191));
        return AW'($urandom_range(0, 31));
    endfunction

    task automatic apply_drive();
        for (int i = 0; i < N; i++) begin
            req_write[i]            = drv_write[i];
            req_addr[i*AW +: AW]    = drv_addr[i];
            req_wdata[i*DW +: DW]   = drv_wdata[i];
        end
    endtask

    task automatic run_batch(input logic [N-1:0] mask, input int n_grants, input bit keep, input int wd_idx);
        logic [N-1:0] pend;
        int           grants;
        int           budget;
        int           next_g;
        int           k;
        exp_t         e;
        pend   = mask;
        grants = 0;
        budget = 400;
        next_g = -1;
        @(posedge clk);
        #1;
        apply_drive();
        req_valid = mask;
        while ((pend != '0 || exp_q.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
            if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                chk("resp_valid", 32'(resp_valid), 32'(1) << e.idx);
                chk("resp_data", 32'(resp_data), 32'(e.data));
                chk("resp_error", 32'(resp_error), 32'(e.err));
                chk("timeout_pulse", 32'(timeout), 32'(e.tmo));
                chk("busy_in_resp", 32'(busy), 32'd1);
                last_data = resp_data;
                last_err  = resp_error;
                last_tmo  = timeout;
            end else begin
                chk("no_resp", 32'(resp_valid), 32'd0);
                chk("no_timeout", 32'(timeout), 32'd0);
            end
            if (req_ready != '0) begin
                k = rr_next(pend, model_last);
                chk("grant_idx", 32'(req_ready), (k < 0) ? 32'd0 : (32'(1) << k));
                chk("busy_at_grant", 32'(busy), 32'd0);
                if (next_g >= 0) chk("grant_spacing", cyc, next_g);
                if (k >= 0) begin
                    e.idx = k;
                    e.tmo = 1'b0;
                    e.cyc = cyc + 4;
                    e.data = '0;
                    if (drv_write[k]) begin
                        e.err = (int'(drv_addr[k]) >= DEPTH);
                        if (!e.err) model_mem[drv_addr[k]] = drv_wdata[k];
                    end else if (stall_read) begin
                        e.err = 1'b1;
                        e.tmo = 1'b1;
                        e.cyc = cyc + 2 + TO;
                    end else begin
                        e.err = (int'(drv_addr[k]) >= DEPTH);
                        e.data = e.err ? '0 : model_mem[drv_addr[k]];
                    end
                    exp_q.push_back(e);
                    next_g     = e.cyc + 1;
                    model_last = k;
                    grants++;
                    @(posedge clk);
                    #1;
                    if (keep && grants < n_grants) begin
                        drv_addr[k] = rand_addr();
                    end else begin
                        req_valid[k] = 1'b0;
                        pend[k]      = 1'b0;
                        drv_addr[k]  = AW'($urandom);
                        drv_wdata[k] = DW'($urandom);
                    end
                    if (grants == n_grants) begin
                        req_valid = '0;
                        pend      = '0;
                    end
                    if (wd_idx >= 0 && grants == 1) begin
                        req_valid[wd_idx] = 1'b0;
                        pend[wd_idx]      = 1'b0;
                    end
                    apply_drive();
                end
            end
        end
        chk("batch_in_budget", 32'(budget > 0), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_data"}, 32'(resp_data), 32'd0);
        chk({tag, "_resp_error"}, 32'(resp_error), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_strobes"}, 32'({mem_read, mem_write}), 32'd0);
        chk({tag, "_addrs"}, 32'({mem_read_addr, mem_write_addr}), 32'd0);
        chk({tag, "_wdata"}, 32'(mem_data_in), 32'd0);
    endtask

    logic [N-1:0] rmask;
    int           wd;

    initial begin
        reset      = 1'b0;
        model_last = N - 1;
        for (int i = 0; i < N; i++) begin
            drv_write[i] = 1'b0;
            drv_addr[i]  = AW'(i);
            drv_wdata[i] = '0;
        end
        apply_drive();
        req_valid = '1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        req_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Four continuous readers from reset: grants 0,1,2,3,0 spaced 5 cycles
        for (int i = 0; i < N; i++) drv_addr[i] = rand_addr();
        run_batch(4'b1111, 5, 1'b1, -1);

        // Requester 1 writes 0xBEEF to 0x005 then reads it back
        drv_write[1] = 1'b1; drv_addr[1] = 13'h005; drv_wdata[1] = 16'hBEEF;
        run_batch(4'b0010, 1, 1'b0, -1);
        chk("write_err", 32'(last_err), 32'd0);
        drv_write[1] = 1'b0; drv_addr[1] = 13'h005;
        run_batch(4'b0010, 1, 1'b0, -1);
        chk("read_back_beef", 32'(last_data), 32'h0000BEEF);

        // Out-of-range read and write, then a valid read
        drv_write[2] = 1'b0; drv_addr[2] = 13'h1800;
        run_batch(4'b0100, 1, 1'b0, -1);
        chk("oor_read_err", 32'(last_err), 32'd1);
        drv_write[2] = 1'b1; drv_addr[2] = 13'h1800; drv_wdata[2] = 16'h1234;
        run_batch(4'b0100, 1, 1'b0, -1);
        chk("oor_write_err", 32'(last_err), 32'd1);
        drv_write[2] = 1'b0; drv_addr[2] = 13'h0005;
        run_batch(4'b0100, 1, 1'b0, -1);
        chk("valid_after_oor_err", 32'(last_err), 32'd0);

        // Read ready held low: timeout 16 cycles into WAIT, busy drops after RESP
        stall_read = 1'b1;
        drv_write[0] = 1'b0; drv_addr[0] = 13'h0003;
        run_batch(4'b0001, 1, 1'b0, -1);
        chk("timeout_seen", 32'(last_tmo), 32'd1);
        @(negedge clk);
        chk("busy_after_timeout", 32'(busy), 32'd0);
        stall_read = 1'b0;

        // Reset asserted during WAIT
        drv_write[1] = 1'b0; drv_addr[1] = 13'h0007;
        apply_drive();
        @(posedge clk);
        #1;
        req_valid = 4'b0010;
        for (int w = 0; w < 20 && req_ready == '0; w++) @(negedge clk);
        chk("pre_reset_grant", 32'(req_ready), 32'b0010);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_all_zero("mid_op_reset");
        model_last = N - 1;
        drv_write[0] = 1'b1; drv_addr[0] = 13'h0009; drv_wdata[0] = DW'($urandom);
        drv_write[3] = 1'b1; drv_addr[3] = 13'h000A; drv_wdata[3] = DW'($urandom);
        repeat (4) @(negedge clk);
        chk("no_resp_in_reset", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_batch(4'b1001, 2, 1'b0, -1);

        // Requester 2 withdraws while requester 0 is in flight
        for (int i = 0; i < N; i++) begin
            drv_write[i] = 1'b0;
            drv_addr[i]  = rand_addr();
        end
        run_batch(4'b1101, 2, 1'b0, 2);

        // Randomized contention batches
        for (int b = 0; b < 12; b++) begin
            rmask = N'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                drv_write[i] = 1'($urandom_range(0, 1));
                drv_addr[i]  = rand_addr();
                drv_wdata[i] = DW'($urandom);
            end
            wd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
            run_batch(rmask, $countones(rmask), 1'b0, wd);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
